// File: rtl/cnt_tc_irq_coalesce.sv
// Coalesces terminal-count events into a level interrupt, fired either at a
// pending-count threshold or after a timeout measured from the first unserviced event.
module cnt_tc_irq_coalesce #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TMO_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             tc_i,
    input  logic [CNT_W-1:0] thr_i,
    input  logic [TMO_W-1:0] tmo_i,
    input  logic             ack_i,
    output logic             irq_o,
    output logic [CNT_W-1:0] pend_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {StIdle, StAccum, StFire} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   pend_q, pend_d;
    logic [TMO_W-1:0]   timer_q, timer_d;
    logic               ovf_q, ovf_d;
    logic               irq_q, irq_d;
    logic               tc_q;

    logic               evt;
    logic               pend_sat;
    logic               tmo_hit;
    logic [CNT_W-1:0]   thr_eff;
    logic [CNT_W-1:0]   pend_inc;
    state_e             first_state;

    assign evt         = en_i & tc_i & ~tc_q;
    assign thr_eff     = (thr_i == '0) ? CNT_W'(1) : thr_i;
    assign pend_sat    = &pend_q;
    assign pend_inc    = pend_sat ? pend_q : pend_q + CNT_W'(1);
    // Timer starts at 0 on ACCUM entry, so this lands exactly tmo_i cycles later.
    assign tmo_hit     = (tmo_i != '0) && (timer_q == tmo_i - TMO_W'(1));
    assign first_state = (thr_eff == CNT_W'(1)) ? StFire : StAccum;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        timer_d = timer_q;
        if (!en_i) begin
            state_d = StIdle;
            pend_d  = '0;
            ovf_d   = 1'b0;
            timer_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (evt) begin
                        pend_d  = CNT_W'(1);
                        timer_d = '0;
                        state_d = first_state;
                    end
                end
                StAccum: begin
                    timer_d = (&timer_q) ? timer_q : timer_q + TMO_W'(1);
                    if (evt) begin
                        pend_d = pend_inc;
                        if (pend_sat) ovf_d = 1'b1;
                    end
                    // Also catches a threshold lowered to or below the current count.
                    if ((pend_d >= thr_eff) || tmo_hit) state_d = StFire;
                end
                StFire: begin
                    if (ack_i) begin
                        ovf_d   = 1'b0;
                        timer_d = '0;
                        if (evt) begin
                            pend_d  = CNT_W'(1);
                            state_d = first_state;
                        end else begin
                            pend_d  = '0;
                            state_d = StIdle;
                        end
                    end else if (evt) begin
                        pend_d = pend_inc;
                        if (pend_sat) ovf_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        irq_d = (state_d == StFire);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pend_q  <= '0;
            timer_q <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
            tc_q    <= tc_i;
        end
    end

    assign irq_o  = irq_q;
    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;

endmodule
